// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fft_pkg
// Description : Shared FSM state codes, default twiddle ROM base address and a
//               log2 helper for the FFT twiddle sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package fft_pkg;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_GAP   = 2'd2;
    localparam logic [1:0] c_ST_DRAIN = 2'd3;

    localparam int TW_BASE_DEF = 0;

    // Ceiling log2; also used at elaboration time to size ports.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_bfly_index_gen.sv
`default_nettype none
// ============================================================================
// Module      : fft_bfly_index_gen
// Description : Combinational radix-2 DIT butterfly addressing: (stage, bfly)
//               -> twiddle index k and operand indices idx_a / idx_b.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_bfly_index_gen
    import fft_pkg::*;
#(
    parameter int N_POINTS = 8
) (
    input  logic [clog2(clog2(N_POINTS)+1)-1:0] i_stage,
    input  logic [clog2(N_POINTS)-2:0]          i_bfly,
    output logic [clog2(N_POINTS)-1:0]          o_k,
    output logic [clog2(N_POINTS)-1:0]          o_idx_a,
    output logic [clog2(N_POINTS)-1:0]          o_idx_b
);

    localparam int L  = clog2(N_POINTS);
    localparam int SW = clog2(L + 1);

    logic [L-1:0]  w_b;
    logic [L-1:0]  w_half;
    logic [L-1:0]  w_p;
    logic [L-1:0]  w_j;
    logic [SW-1:0] w_sh;

    // half = 2^s, p = b mod half, j = b / half
    always_comb begin
        w_b     = {1'b0, i_bfly};
        w_half  = L'(1) << i_stage;
        w_p     = w_b & (w_half - L'(1));
        w_j     = w_b >> i_stage;
        w_sh    = SW'(L - 1) - i_stage;
        o_k     = w_p << w_sh;
        o_idx_a = (w_j << (i_stage + SW'(1))) | w_p;
        o_idx_b = o_idx_a + w_half;
    end

endmodule
`default_nettype wire

// File: rtl/fft_twiddle_seq.sv
`default_nettype none
// ============================================================================
// Module      : fft_twiddle_seq
// Description : Twiddle ROM address / butterfly index sequencer with a
//               valid/ready output aligned to the 1-cycle ROM latency.
//               Define FFT_TW_SEQ_STAGE_GAP_EN for a one-cycle bubble between
//               stages (ping-pong buffer swap).
// Revision    : 1.0 - initial release
// ============================================================================
module fft_twiddle_seq
    import fft_pkg::*;
#(
    parameter int N_POINTS = 8,
    parameter int ADDR_W   = 5,
    parameter int TW_BASE  = TW_BASE_DEF
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic                                 abort,
    output logic [ADDR_W-1:0]                    rom_addr,
    output logic                                 tw_valid,
    input  logic                                 tw_ready,
    output logic [clog2(N_POINTS)-1:0]           idx_a,
    output logic [clog2(N_POINTS)-1:0]           idx_b,
    output logic [clog2(clog2(N_POINTS)+1)-1:0]  stage,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 stage_done
);

    localparam int L  = clog2(N_POINTS);
    localparam int SW = clog2(L + 1);
    localparam int BW = L - 1;
    localparam logic [BW-1:0] c_B_LAST = BW'(N_POINTS / 2 - 1);
    localparam logic [SW-1:0] c_S_LAST = SW'(L - 1);

    logic [1:0]        r_state;
    logic [SW-1:0]     r_s;
    logic [BW-1:0]     r_b;
    // Pending slot: address issued to the ROM, data not yet presented.
    logic              r_pend_v;
    logic              r_pend_last;
    logic              r_pend_fin;
    logic [L-1:0]      r_pend_a;
    logic [L-1:0]      r_pend_b;
    logic [SW-1:0]     r_pend_st;
    logic [ADDR_W-1:0] r_addr;
    // Output slot: item currently presented with ROM data.
    logic              r_valid;
    logic              r_last;
    logic              r_fin;
    logic [L-1:0]      r_idx_a;
    logic [L-1:0]      r_idx_b;
    logic [SW-1:0]     r_stage;
    logic [ADDR_W-1:0] r_addr_o;

    logic [L-1:0]      w_k;
    logic [L-1:0]      w_a;
    logic [L-1:0]      w_b_idx;
    logic              w_adv;
    logic              w_acc;
    logic              w_stage_done;
    logic              w_done;
    logic              w_last_b;
    logic              w_last_s;
    logic              w_hold;
    logic              w_gap_go;
    logic              w_issue;

    fft_bfly_index_gen #(
        .N_POINTS (N_POINTS)
    ) u_idx (
        .i_stage  (r_s),
        .i_bfly   (r_b),
        .o_k      (w_k),
        .o_idx_a  (w_a),
        .o_idx_b  (w_b_idx)
    );

    assign w_adv        = !r_valid || tw_ready;
    assign w_acc        = r_valid && tw_ready;
    assign w_stage_done = w_acc && r_last && !abort;
    assign w_done       = w_stage_done && r_fin;
    assign w_last_b     = (r_b == c_B_LAST);
    assign w_last_s     = (r_s == c_S_LAST);

`ifdef FFT_TW_SEQ_STAGE_GAP_EN
    // First item of a new stage waits until the previous stage is fully accepted.
    assign w_hold   = (r_state == c_ST_RUN) && (r_b == '0) && (r_s != '0) && !w_stage_done;
    assign w_gap_go = w_stage_done;
`else
    assign w_hold   = 1'b0;
    assign w_gap_go = 1'b0;
`endif

    assign w_issue = w_adv && !abort &&
                     (((r_state == c_ST_IDLE) && start) ||
                      (((r_state == c_ST_RUN) || (r_state == c_ST_GAP)) && !w_hold));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_s         <= '0;
            r_b         <= '0;
            r_pend_v    <= 1'b0;
            r_pend_last <= 1'b0;
            r_pend_fin  <= 1'b0;
            r_pend_a    <= '0;
            r_pend_b    <= '0;
            r_pend_st   <= '0;
            r_addr      <= ADDR_W'(TW_BASE);
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_fin       <= 1'b0;
            r_idx_a     <= '0;
            r_idx_b     <= '0;
            r_stage     <= '0;
            r_addr_o    <= ADDR_W'(TW_BASE);
        end else if (abort) begin
            r_state  <= c_ST_IDLE;
            r_s      <= '0;
            r_b      <= '0;
            r_pend_v <= 1'b0;
            r_valid  <= 1'b0;
            r_addr   <= ADDR_W'(TW_BASE);
        end else begin
            if (w_adv) begin
                r_valid  <= r_pend_v;
                r_last   <= r_pend_last;
                r_fin    <= r_pend_fin;
                r_idx_a  <= r_pend_a;
                r_idx_b  <= r_pend_b;
                r_stage  <= r_pend_st;
                r_addr_o <= r_addr;
                r_pend_v <= 1'b0;
            end
            if (w_issue) begin
                r_pend_v    <= 1'b1;
                r_pend_last <= w_last_b;
                r_pend_fin  <= w_last_b && w_last_s;
                r_pend_a    <= w_a;
                r_pend_b    <= w_b_idx;
                r_pend_st   <= r_s;
                r_addr      <= ADDR_W'(TW_BASE) + ADDR_W'(w_k);
                if (w_last_b) begin
                    r_b <= '0;
                    r_s <= r_s + SW'(1);
                end else begin
                    r_b <= r_b + BW'(1);
                end
            end
            case (r_state)
                c_ST_IDLE: begin
                    if (w_issue) r_state <= c_ST_RUN;
                end
                c_ST_RUN: begin
                    if (w_issue && w_last_b && w_last_s) r_state <= c_ST_DRAIN;
                    else if (w_gap_go)                   r_state <= c_ST_GAP;
                end
                c_ST_GAP: begin
                    r_state <= c_ST_RUN;
                end
                c_ST_DRAIN: begin
                    if (w_done) begin
                        r_state <= c_ST_IDLE;
                        r_s     <= '0;
                        r_b     <= '0;
                        r_addr  <= ADDR_W'(TW_BASE);
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    // While stalled the ROM re-reads the presented address so its data holds.
    assign rom_addr   = (r_valid && !tw_ready) ? r_addr_o : r_addr;
    assign tw_valid   = r_valid;
    assign idx_a      = r_idx_a;
    assign idx_b      = r_idx_b;
    assign stage      = r_stage;
    assign busy       = (r_state != c_ST_IDLE);
    assign done       = w_done;
    assign stage_done = w_stage_done;

endmodule
`default_nettype wire

// File: tb/tb_fft_twiddle_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_twiddle_seq
// Description : Directed self-checking bench for fft_twiddle_seq (N_POINTS=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_twiddle_seq;

    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic          tw_ready;
    logic [AW-1:0] rom_addr;
    logic          tw_valid;
    logic [2:0]    idx_a;
    logic [2:0]    idx_b;
    logic [1:0]    stage;
    logic          busy;
    logic          done;
    logic          stage_done;
    logic [AW-1:0] rom_q;

    fft_twiddle_seq #(
        .N_POINTS (8),
        .ADDR_W   (AW),
        .TW_BASE  (0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .rom_addr   (rom_addr),
        .tw_valid   (tw_valid),
        .tw_ready   (tw_ready),
        .idx_a      (idx_a),
        .idx_b      (idx_b),
        .stage      (stage),
        .busy       (busy),
        .done       (done),
        .stage_done (stage_done)
    );

    always #5 clk = ~clk;

    // ROM with one cycle of read latency; data word equals the twiddle index.
    always @(posedge clk) rom_q <= rom_addr;

    typedef struct {
        int addr;
        int a;
        int b;
        int st;
    } vec_t;

    vec_t exp_tab[12];
    int   got[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   done_cnt;
    int   sd_cnt;
    int   bubbles;
    int   done_t;

`ifdef FFT_TW_SEQ_STAGE_GAP_EN
    localparam int EXP_DONE_T  = 15;
    localparam int EXP_BUBBLES = 2;
`else
    localparam int EXP_DONE_T  = 13;
    localparam int EXP_BUBBLES = 0;
`endif

    function automatic int pack(input int addr, input int a, input int b, input int st);
        return addr * 1000 + a * 100 + b * 10 + st;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic obs();
        #1;
        if (tw_valid && tw_ready) got.push_back(pack(int'(rom_q), int'(idx_a), int'(idx_b), int'(stage)));
        if (done) done_cnt++;
        if (stage_done) sd_cnt++;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_tw_valid"}, int'(tw_valid), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_stage_done"}, int'(stage_done), 0);
        chk({tag, "_rom_addr"}, int'(rom_addr), 0);
        chk({tag, "_idx_a"}, int'(idx_a), 0);
        chk({tag, "_idx_b"}, int'(idx_b), 0);
        chk({tag, "_stage"}, int'(stage), 0);
    endtask

    task automatic cmp_tab(input string tag);
        chk({tag, "_n_items"}, got.size(), 12);
        for (int i = 0; i < 12; i++) begin
            if (i < got.size())
                chk($sformatf("%s_item%0d", tag, i), got[i],
                    pack(exp_tab[i].addr, exp_tab[i].a, exp_tab[i].b, exp_tab[i].st));
        end
    endtask

    // One FFT pass; t counts cycles from the cycle in which start is high.
    task automatic pass(input int stall_at, input int abort_at, input bit rst_s2, input int busy_start_at);
        int stalls;
        bit first_seen;
        got.delete();
        done_cnt   = 0;
        sd_cnt     = 0;
        bubbles    = 0;
        done_t     = -1;
        stalls     = 0;
        first_seen = 1'b0;
        @(negedge clk);
        start = 1'b1; abort = 1'b0; tw_ready = 1'b1; rst = 1'b0;
        obs();
        for (int t = 1; t <= 60; t++) begin
            @(negedge clk);
            start    = (t == busy_start_at);
            tw_ready = 1'b1;
            abort    = 1'b0;
            rst      = 1'b0;
            if (tw_valid && got.size() == stall_at && stalls < 3) begin
                tw_ready = 1'b0;
                stalls++;
            end
            if (tw_valid && got.size() == abort_at) abort = 1'b1;
            if (rst_s2 && tw_valid && stage == 2'd2) rst = 1'b1;
            obs();
            if (!tw_ready) begin
                chk("stall_valid", int'(tw_valid), 1);
                chk("stall_rom_addr", int'(rom_addr), 2);
                chk("stall_rom_data", int'(rom_q), 2);
                chk("stall_idx", int'(idx_a) * 10 + int'(idx_b), 13);
            end
            if (tw_valid) first_seen = 1'b1;
            else if (first_seen && busy) bubbles++;
            if (done) begin
                done_t = t;
                break;
            end
            if (abort || rst) break;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_tab[0]  = '{0, 0, 1, 0};
        exp_tab[1]  = '{0, 2, 3, 0};
        exp_tab[2]  = '{0, 4, 5, 0};
        exp_tab[3]  = '{0, 6, 7, 0};
        exp_tab[4]  = '{0, 0, 2, 1};
        exp_tab[5]  = '{2, 1, 3, 1};
        exp_tab[6]  = '{0, 4, 6, 1};
        exp_tab[7]  = '{2, 5, 7, 1};
        exp_tab[8]  = '{0, 0, 4, 2};
        exp_tab[9]  = '{1, 1, 5, 2};
        exp_tab[10] = '{2, 2, 6, 2};
        exp_tab[11] = '{3, 3, 7, 2};

        rst = 1'b1; start = 1'b0; abort = 1'b0; tw_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk_reset_vals("reset");
        rst = 1'b0;

        // Full pass at full throughput
        pass(-1, -1, 1'b0, -1);
        cmp_tab("full");
        chk("full_done_latency", done_t, EXP_DONE_T);
        chk("full_done_count", done_cnt, 1);
        chk("full_stage_done_count", sd_cnt, 3);
        chk("full_bubbles", bubbles, EXP_BUBBLES);
        @(negedge clk); #1;
        chk("full_idle_busy", int'(busy), 0);

        // Back-pressure on item 5
        pass(5, -1, 1'b0, -1);
        cmp_tab("stall");
        chk("stall_done_count", done_cnt, 1);

        // Abort on item 7
        pass(-1, 7, 1'b0, -1);
        chk("abort_items", got.size(), 8);
        chk("abort_stage_done_count", sd_cnt, 1);
        @(negedge clk);
        abort = 1'b0;
        obs();
        chk("abort_busy", int'(busy), 0);
        chk("abort_tw_valid", int'(tw_valid), 0);
        repeat (3) begin
            @(negedge clk);
            obs();
        end
        chk("abort_no_done", done_cnt, 0);

        // Replay after abort
        pass(-1, -1, 1'b0, -1);
        cmp_tab("replay");
        chk("replay_done_latency", done_t, EXP_DONE_T);

        // Reset during stage 2
        pass(-1, -1, 1'b1, -1);
        @(negedge clk);
        rst = 1'b0;
        tw_ready = 1'b1;
        #1;
        chk_reset_vals("midrst");
        chk("midrst_no_done", done_cnt, 0);

        // Start while busy is ignored
        pass(-1, -1, 1'b0, 5);
        cmp_tab("busystart");
        chk("busystart_done_latency", done_t, EXP_DONE_T);
        chk("busystart_done_count", done_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fft_twiddle_seq.md
FFT_TWIDDLE_SEQ -- requirements
Module: fft_twiddle_seq

Interface
REQ-001 SHALL have parameter N_POINTS, default 8, FFT size (power of two, 4..64).
REQ-002 SHALL have parameter ADDR_W, default 5, twiddle ROM address width.
REQ-003 SHALL have parameter TW_BASE, default 0, ROM address of twiddle index k=0.
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a full FFT twiddle pass.
REQ-007 SHALL have port abort  input  1  synchronous cancel of the current pass.
REQ-008 SHALL have port rom_addr  output  ADDR_W  address driven to both real and imaginary twiddle ROMs (1-cycle read latency).
REQ-009 SHALL have port tw_valid  output  1  ROM data_out, idx_a, idx_b and stage describe one butterfly.
REQ-010 SHALL have port tw_ready  input  1  downstream butterfly accepts the current item.
REQ-011 SHALL have ports idx_a, idx_b  output  log2(N_POINTS)  butterfly operand indices aligned with ROM data.
REQ-012 SHALL have port stage  output  log2(log2(N_POINTS))+1  stage number aligned with ROM data.
REQ-013 SHALL have ports busy, done, stage_done  output  1 each  status; done and stage_done are one-cycle pulses.

Function
REQ-014 SHALL implement FSM IDLE -> RUN -> (GAP) -> RUN ... -> DRAIN -> IDLE; GAP exists only per REQ-027.
REQ-015 SHALL leave IDLE on start=1, setting s=0, b=0 and rom_addr=TW_BASE on the next edge; start outside IDLE is ignored.
REQ-016 SHALL iterate L=log2(N_POINTS) stages s, each with N_POINTS/2 butterflies b; half=2^s, p=b mod half, j=b/half.
REQ-017 SHALL compute k = p << (L-1-s), rom_addr = TW_BASE + k (modulo 2^ADDR_W), idx_a = 2*half*j + p, idx_b = idx_a + half.
REQ-018 SHALL define advance = !tw_valid || tw_ready; counters, rom_addr and the pending idx/stage registers update only when advance=1.
REQ-019 SHALL assert tw_valid exactly one cycle after an address is issued and hold tw_valid, idx_a, idx_b, stage and rom_addr stable while tw_valid && !tw_ready.
REQ-020 SHALL pulse stage_done in the cycle the last butterfly of a stage is accepted (tw_valid && tw_ready).
REQ-021 SHALL enter DRAIN after issuing the last address of stage L-1, then pulse done and return to IDLE on acceptance of that final item.
REQ-022 SHALL, on abort=1 in any state, deassert tw_valid and busy on the next edge, return to IDLE, and not pulse done; abort wins over start in the same cycle.
REQ-023 SHALL hold busy=1 in every state except IDLE.
REQ-024 SHALL sustain one butterfly per cycle when tw_ready is held high (12 items in 13 cycles after start for N_POINTS=8, no GAP).

Reset
REQ-025 SHALL on rst=1 force state IDLE, rom_addr=TW_BASE, tw_valid=0, idx_a=0, idx_b=0, stage=0, busy=0, done=0, stage_done=0.
REQ-026 SHALL give rst priority over abort and start, including mid-pass.

Configuration
REQ-027 SHALL, when macro FFT_TW_SEQ_STAGE_GAP_EN is defined, enter GAP for exactly one cycle after each non-final stage_done (tw_valid=0, busy=1) for ping-pong buffer swap; without the macro, stages run back-to-back with no bubble.

Structure
REQ-028 SHALL place FSM state enum, TW_BASE default and the log2 helper constant function in shared package fft_pkg.
REQ-029 SHALL instantiate one sub-module fft_bfly_index_gen (combinational s,b -> k, idx_a, idx_b); the FSM and ROM-latency alignment remain in the top.

Verification
REQ-030 SHALL check: N_POINTS=8, start, tw_ready=1 -> rom_addr sequence 0,0,0,0, 0,2,0,2, 0,1,2,3; done pulses 13 cycles after start.
REQ-031 SHALL check: stage 1 -> (idx_a,idx_b) = (0,2),(1,3),(4,6),(5,7); stage 2 -> (0,4),(1,5),(2,6),(3,7).
REQ-032 SHALL check: tw_ready=0 for 3 cycles on item 5 -> tw_valid, rom_addr=2 and ROM data held; no item dropped or duplicated.
REQ-033 SHALL check: abort asserted on item 7 -> IDLE next cycle, busy=0, no done; a new start then replays from rom_addr=0.
REQ-034 SHALL check: rst during stage 2 -> all outputs at reset values next cycle; start asserted while busy=1 has no effect.
REQ-035 SHALL check: with FFT_TW_SEQ_STAGE_GAP_EN, one tw_valid=0 cycle after each of stage 0 and stage 1; done pulses 15 cycles after start.
